// File: rtl/mem_rr_ram.sv
// N-channel single-port RAM with a round-robin arbiter in front.
// One access per clock. Read data comes back through a two-stage response pipe with error flags.
module mem_rr_ram #(
  parameter int unsigned W      = 32,
  parameter int unsigned addr_w = 8,
  parameter int unsigned DEPTH  = 2 ** addr_w,
  parameter int unsigned N      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N-1:0]          valid_i,
  input  logic [N-1:0]          wrd_i,
  input  logic [N*addr_w-1:0]   addr_i,
  input  logic [N*W-1:0]        wdata_i,
  input  logic [N*(W/8)-1:0]    be_i,
  output logic [N-1:0]          ready_o,
  output logic [N*W-1:0]        rdata_o,
  output logic [N-1:0]          rvalid_o,
  output logic [N-1:0]          err_o
);
  localparam int unsigned NB = W / 8;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  int unsigned     cand;

  logic            acc;
  logic            sel_wr;
  logic            in_range;
  logic [addr_w-1:0] sel_addr;
  logic [AW-1:0]   mem_idx;
  logic [W-1:0]    sel_wdata;
  logic [NB-1:0]   sel_be;

  logic [N-1:0]    pend_rd_q, pend_rd_d;
  logic [N-1:0]    pend_err_q, pend_err_d;
  logic [W-1:0]    pend_data_q, pend_data_d;
  logic [N-1:0]    rvalid_q, err_q;
  logic [N*W-1:0]  rdata_q, rdata_d;

  // Search starts one past the last winner, so ptr reset to N-1 favours ch0.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr_q) + off) % N;
      if (!gnt_any && valid_i[cand[PW-1:0]]) begin
        gnt_any              = 1'b1;
        gnt[cand[PW-1:0]]    = 1'b1;
        gnt_idx              = cand[PW-1:0];
      end
    end
  end

  assign ready_o   = rst_ni ? gnt : '0;
  assign acc       = rst_ni & gnt_any;
  assign sel_wr    = wrd_i[gnt_idx];
  assign sel_addr  = addr_i[32'(gnt_idx) * addr_w +: addr_w];
  assign sel_wdata = wdata_i[32'(gnt_idx) * W +: W];
  assign sel_be    = be_i[32'(gnt_idx) * NB +: NB];
  assign in_range  = 32'(sel_addr) < DEPTH;
  assign mem_idx   = AW'(sel_addr);
  assign ptr_d     = acc ? gnt_idx : ptr_q;

  // Storage is deliberately left unreset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (acc && sel_wr && in_range) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (sel_be[k]) mem_q[mem_idx][k*8 +: 8] <= sel_wdata[k*8 +: 8];
      end
    end
  end

  always_comb begin
    pend_rd_d   = '0;
    pend_err_d  = '0;
    pend_data_d = pend_data_q;
    if (acc) begin
      pend_rd_d[gnt_idx]  = ~sel_wr;
      pend_err_d[gnt_idx] = ~in_range;
      if (!sel_wr) pend_data_d = in_range ? mem_q[mem_idx] : '0;
    end
    rdata_d = rdata_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_rd_q[i]) rdata_d[i*W +: W] = pend_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= PW'(N - 1);
      pend_rd_q   <= '0;
      pend_err_q  <= '0;
      pend_data_q <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pend_rd_q   <= pend_rd_d;
      pend_err_q  <= pend_err_d;
      pend_data_q <= pend_data_d;
      rvalid_q    <= pend_rd_q;
      err_q       <= pend_err_q;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_rr_ram.sv
// Randomised and directed bench for mem_rr_ram (W=32, addr_w=4, DEPTH=12, N=2).
// A transaction-level model predicts grants, memory and read responses every cycle.
module tb_mem_rr_ram;
  localparam int N = 2;
  localparam int W = 32;
  localparam int DEPTH = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   valid = '0, wrd = '0;
  logic [N*4-1:0] addr = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N*4-1:0] be = '0;
  logic [N-1:0]   ready, rvalid, err;
  logic [N*W-1:0] rdata;

  int checks = 0;
  int errors = 0;

  mem_rr_ram #(.W(W), .addr_w(4), .DEPTH(DEPTH), .N(N)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid),
    .wrd_i   (wrd),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .ready_o (ready),
    .rdata_o (rdata),
    .rvalid_o(rvalid),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // Reference model: memory array, last-winner pointer, one pending response slot.
  logic [31:0] mm [DEPTH];
  int          m_ptr = N - 1;
  logic [N-1:0] m_rvalid = '0, m_err = '0, p_rd = '0, p_err = '0;
  logic [31:0] m_rdata [N] = '{default: '0};
  logic [31:0] p_data = '0;

  function automatic int mgnt();
    for (int o = 1; o <= N; o++) begin
      int c = (m_ptr + o) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = N - 1;
      m_rvalid = '0; m_err = '0; p_rd = '0; p_err = '0;
      for (int i = 0; i < N; i++) m_rdata[i] = '0;
    end else begin
      int g;
      int a;
      m_rvalid = p_rd;
      m_err = p_err;
      for (int i = 0; i < N; i++) if (p_rd[i]) m_rdata[i] = p_data;
      p_rd = '0; p_err = '0;
      g = mgnt();
      if (g >= 0) begin
        a = int'(addr[g*4 +: 4]);
        m_ptr = g;
        if (a >= DEPTH) begin
          p_err[g] = 1'b1;
          if (!wrd[g]) begin p_rd[g] = 1'b1; p_data = '0; end
        end else if (wrd[g]) begin
          for (int k = 0; k < 4; k++)
            if (be[g*4 + k]) mm[a][k*8 +: 8] = wdata[g*W + k*8 +: 8];
        end else begin
          p_rd[g] = 1'b1;
          p_data = mm[a];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g = mgnt();
    er = (rst_n && g >= 0) ? N'(1 << g) : '0;
    chk("ready", 64'(ready), 64'(er));
    chk("rvalid", 64'(rvalid), 64'(m_rvalid));
    chk("err", 64'(err), 64'(m_err));
    for (int i = 0; i < N; i++) chk("rdata", 64'(rdata[i*W +: W]), 64'(m_rdata[i]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    valid[ch] = v; wrd[ch] = w; addr[ch*4 +: 4] = a; wdata[ch*W +: W] = d; be[ch*4 +: 4] = b;
  endtask

  // Present a lone request on one channel; it must be granted in the same cycle.
  task automatic access(input int ch, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    logic [N-1:0] eg;
    eg = N'(1 << ch);
    set_ch(ch, 1'b1, w, a, d, b);
    @(negedge clk);
    chk("lone_grant", 64'(ready), 64'(eg));
    step();
    valid[ch] = 1'b0;
  endtask

  // Land on the cycle where the response of the last access is visible.
  task automatic resp_slot();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 5; c++) begin
      valid = N'($urandom); wrd = N'($urandom); addr = 8'($urandom);
      wdata = {$urandom, $urandom}; be = 8'($urandom);
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      step();
    end
    set_ch(0, 1'b1, 1'b1, 4'd0, 32'h0, 4'hF);
    set_ch(1, 1'b1, 1'b1, 4'd1, 32'h1, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(ready), 64'h1);
    step();
    valid = '0;

    for (int a = 0; a < DEPTH; a++) access(0, 1'b1, 4'(a), 32'h1000_0000 + 32'(a), 4'hF);

    access(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 4'd3, 32'h0, 4'h0);
    resp_slot();
    chk("rd_rvalid", 64'(rvalid), 64'h1);
    chk("rd_data", 64'(rdata[31:0]), 64'hDEADBEEF);
    chk("rd_err", 64'(err), 64'h0);

    access(0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    access(0, 1'b1, 4'd3, 32'h55667788, 4'b0000);
    access(0, 1'b0, 4'd3, 32'h0, 4'h0);
    resp_slot();
    chk("be_data", 64'(rdata[31:0]), 64'hDE22BE44);

    access(1, 1'b1, 4'd2, 32'h22220002, 4'hF);
    set_ch(0, 1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    set_ch(1, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fair_grant", 64'(ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
    end
    valid = '0;
    @(negedge clk);
    chk("fair_rdata1", 64'(rdata[63:32]), 64'h22220002);

    access(1, 1'b0, 4'd13, 32'h0, 4'h0);
    resp_slot();
    chk("oor_rvalid", 64'(rvalid), 64'h2);
    chk("oor_err", 64'(err), 64'h2);
    chk("oor_rdata", 64'(rdata[63:32]), 64'h0);
    access(1, 1'b1, 4'd14, 32'hBAD0BAD0, 4'hF);
    resp_slot();
    chk("oorw_err", 64'(err), 64'h2);
    chk("oorw_rvalid", 64'(rvalid), 64'h0);
    access(1, 1'b0, 4'd2, 32'h0, 4'h0);
    resp_slot();
    chk("oorw_keep", 64'(rdata[63:32]), 64'h22220002);

    access(0, 1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
    access(0, 1'b0, 4'd5, 32'h0, 4'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", 64'(rvalid), 64'h0);
    chk("midrst_rdata", 64'(rdata[31:0]), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 64'(rvalid), 64'h0);
    step();
    access(0, 1'b0, 4'd5, 32'h0, 4'h0);
    resp_slot();
    chk("post_rst_data", 64'(rdata[31:0]), 64'hCAFEF00D);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        set_ch(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, 4'($urandom));
      end
      step();
    end
    valid = '0;
    step();
    step();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
